// File: rtl/snax_tcdm_stream_reader.sv
// Strided TCDM read streamer: issues element reads under a FIFO credit limit and
// returns the data in order on a ready/valid stream. Macro SNAX_STREAM_PERF_CNT_EN adds perf_cycles_o.
module snax_tcdm_stream_reader #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned FifoDepth  = 4,
  parameter type         tcdm_req_t = logic,
  parameter type         tcdm_rsp_t = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_stride_i,
  input  logic [15:0]          cfg_len_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output tcdm_req_t            tcdm_req_o,
  input  tcdm_rsp_t            tcdm_rsp_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 data_valid_o,
`ifdef SNAX_STREAM_PERF_CNT_EN
  output logic [31:0]          perf_cycles_o,
`endif
  input  logic                 data_ready_i
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // ISSUE  | sending element reads, bounded by FIFO credits
  // DRAIN  | all reads sent, waiting for responses and stream pops
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned SumW      = CntW + 1;
  localparam logic [SumW-1:0] DepthC = SumW'(FifoDepth);

  // Bit layout the TCDM request/response structs are expected to have.
  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
  } q_chan_t;
  typedef struct packed {
    q_chan_t q;
    logic    q_valid;
  } req_flat_t;
  typedef struct packed {
    logic [DataWidth-1:0] data;
  } p_chan_t;
  typedef struct packed {
    p_chan_t p;
    logic    p_valid;
    logic    q_ready;
  } rsp_flat_t;

  req_flat_t req_s;
  rsp_flat_t rsp_s;

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] stride_q, stride_d;
  logic [15:0]          len_q, len_d;
  logic [15:0]          idx_q, idx_d;
  logic                 zero_len_q, zero_len_d;
  logic [CntW-1:0]      out_q, out_d;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [DataWidth-1:0] mem_q [FifoDepth];

  logic [SumW-1:0] credit_sum;
  logic            q_valid, hs, push, pop, drain_done;

  assign rsp_s      = rsp_flat_t'(tcdm_rsp_i);
  assign credit_sum = SumW'(fifo_cnt_q) + SumW'(out_q);
  assign q_valid    = (state_q == StIssue) && (credit_sum < DepthC);
  assign hs         = q_valid & rsp_s.q_ready;
  // Responses with nothing outstanding (e.g. left over from before a reset) are dropped.
  assign push       = rsp_s.p_valid & (out_q != '0);
  assign pop        = data_valid_o & data_ready_i;
  assign drain_done = (state_q == StDrain) && (out_q == '0) && (fifo_cnt_q == '0);

  assign busy_o       = (state_q != StIdle);
  assign done_o       = zero_len_q | drain_done;
  assign data_valid_o = (fifo_cnt_q != '0);
  assign data_o       = data_valid_o ? mem_q[rptr_q] : '0;

  always_comb begin
    req_s         = '0;
    req_s.q_valid = q_valid;
    req_s.q.addr  = addr_q;
    req_s.q.write = 1'b0;
    req_s.q.data  = '0;
    req_s.q.strb  = '1;
  end
  assign tcdm_req_o = tcdm_req_t'(req_s);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    idx_d      = idx_q;
    zero_len_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (cfg_len_i != 16'd0) begin
            state_d  = StIssue;
            addr_d   = cfg_base_i;
            stride_d = cfg_stride_i;
            len_d    = cfg_len_i;
            idx_d    = '0;
          end else begin
            zero_len_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (hs) begin
          addr_d = addr_q + stride_q;
          idx_d  = idx_q + 16'd1;
          if (idx_q == len_q - 16'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q;
    case ({hs, push})
      2'b10:   out_d = out_q + CntW'(1);
      2'b01:   out_d = out_q - CntW'(1);
      default: out_d = out_q;
    endcase
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      zero_len_q <= 1'b0;
      out_q      <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      zero_len_q <= zero_len_d;
      out_q      <= out_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        mem_q[wptr_q] <= rsp_s.p.data;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
    end
  end

`ifdef SNAX_STREAM_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      perf_q <= '0;
    end else if (busy_o && !(&perf_q)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_snax_tcdm_stream_reader.sv
// Bench for snax_tcdm_stream_reader: 1-cycle TCDM memory model, randomized stalls,
// expectations from base + k*stride arithmetic and an in-order element count.
module tb_snax_tcdm_stream_reader;

  localparam int DW = 64;
  localparam int AW = 48;
  localparam int FD = 4;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            write;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
  } q_chan_t;
  typedef struct packed {
    q_chan_t q;
    logic    q_valid;
  } req_t;
  typedef struct packed {
    logic [DW-1:0] data;
  } p_chan_t;
  typedef struct packed {
    p_chan_t p;
    logic    p_valid;
    logic    q_ready;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cfg_base, cfg_stride;
  logic [15:0]   cfg_len;
  logic          start, busy, done, data_valid, data_ready;
  logic [DW-1:0] data;
  req_t          tcdm_req;
  rsp_t          tcdm_rsp;
`ifdef SNAX_STREAM_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  snax_tcdm_stream_reader #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .FifoDepth (FD),
    .tcdm_req_t(req_t),
    .tcdm_rsp_t(rsp_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_base_i  (cfg_base),
    .cfg_stride_i(cfg_stride),
    .cfg_len_i   (cfg_len),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .tcdm_req_o  (tcdm_req),
    .tcdm_rsp_i  (tcdm_rsp),
    .data_o      (data),
    .data_valid_o(data_valid),
`ifdef SNAX_STREAM_PERF_CNT_EN
    .perf_cycles_o(perf_cycles),
`endif
    .data_ready_i(data_ready)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] m_base, m_stride;
  int m_len, n_iss, n_pop, n_resp, n_done, n_busy, n_qv;
  int first_hs, first_pop, last_pop;
  bit rsp_pend = 1'b0;
  logic [DW-1:0] rsp_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int k);
    logic [63:0] a;
    a = 64'(m_base) + 64'(k) * 64'(m_stride);
    return a[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'hC0FFEE11, a[47:32], 16'h5A5A};
  endfunction

  task automatic clear_model(input logic [AW-1:0] b, input logic [AW-1:0] s, input int len);
    m_base = b; m_stride = s; m_len = len;
    n_iss = 0; n_pop = 0; n_resp = 0; n_done = 0; n_busy = 0; n_qv = 0;
    first_hs = -1; first_pop = -1; last_pop = -1;
  endtask

  // One clock cycle: drive memory/stream inputs, observe, advance to just after the next edge.
  task automatic step(input bit qr, input bit dr);
    tcdm_rsp.p_valid = rsp_pend;
    tcdm_rsp.p.data  = rsp_pend ? rsp_data : '0;
    tcdm_rsp.q_ready = qr;
    data_ready       = dr;
    #1;
    if (rsp_pend) begin
      chk("fifo_room", 64'((n_resp - n_pop) < FD), 64'd1);
      n_resp++;
    end
    rsp_pend = 1'b0;
    if (busy) n_busy++;
    if (done) n_done++;
    if (tcdm_req.q_valid) n_qv++;
    if (tcdm_req.q_valid && qr) begin
      chk("req_addr", 64'(tcdm_req.q.addr), 64'(exp_addr(n_iss)));
      chk("req_attr", {55'd0, tcdm_req.q.write, tcdm_req.q.strb}, 64'h0FF);
      chk("req_wdata", tcdm_req.q.data, 64'h0);
      chk("credit", 64'((n_iss - n_pop) < FD), 64'd1);
      if (n_iss == 0) first_hs = cyc;
      rsp_pend = 1'b1;
      rsp_data = mem_word(tcdm_req.q.addr);
      n_iss++;
    end
    if (data_valid && dr) begin
      chk("beat", data, mem_word(exp_addr(n_pop)));
      if (n_pop == 0) first_pop = cyc;
      last_pop = cyc;
      n_pop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] s, input int len,
                          input int qm, input int dm, input bit junk);
    int i;
    bit qr, dr;
    logic [63:0] r;
    clear_model(b, s, len);
    cfg_base = b; cfg_stride = s; cfg_len = 16'(len); start = 1'b1;
    step(1'b1, 1'b1);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    i = 0;
    while (n_done == 0 && i < 600) begin
      qr = (qm == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (dm)
        0:       dr = 1'b1;
        1:       dr = 1'($urandom_range(0, 1));
        2:       dr = (i < 20) ? 1'b0 : 1'b1;
        default: dr = (i % 2 == 0);
      endcase
      if (junk && busy && $urandom_range(0, 3) == 0) begin
        r = {$urandom(), $urandom()};
        start = 1'b1; cfg_base = r[AW-1:0]; cfg_stride = r[63:16]; cfg_len = r[15:0];
      end else begin
        start = 1'b0;
      end
      step(qr, dr);
      if (dm == 2 && i == 19) begin
        chk("stall_issued", 64'(n_iss), 64'((len < FD) ? len : FD));
        chk("stall_popped", 64'(n_pop), 64'd0);
      end
      i++;
    end
    start = 1'b0;
    if (n_done == 0) chk("timeout", 64'd1, 64'd0);
    repeat (3) step(1'b1, 1'b1);
    chk("issued", 64'(n_iss), 64'(len));
    chk("delivered", 64'(n_pop), 64'(len));
    chk("done_pulses", 64'(n_done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    if (qm == 0 && dm == 0) begin
      chk("latency", 64'(first_pop - first_hs), 64'd2);
      chk("throughput", 64'(last_pop - first_hs), 64'(len + 1));
    end
`ifdef SNAX_STREAM_PERF_CNT_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(n_busy));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [63:0] r1, r2;
    rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_len = '0;
    data_ready = 1'b0; tcdm_rsp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dvalid", 64'(data_valid), 64'd0);
    chk("rst_qvalid", 64'(tcdm_req.q_valid), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_addr", 64'(tcdm_req.q.addr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_xfer(48'h0, 48'h8, 4, 0, 0, 0);
    run_xfer(48'h0000_1000_0000, 48'h8, 8, 0, 2, 0);

    // Zero-length start
    clear_model(48'h40, 48'h8, 0);
    cfg_base = 48'h40; cfg_stride = 48'h8; cfg_len = 16'd0; start = 1'b1;
    step(1'b1, 1'b1);
    start = 1'b0;
    chk("zl_done_on_start", 64'(n_done), 64'd0);
    step(1'b1, 1'b1);
    chk("zl_done_next", 64'(n_done), 64'd1);
    repeat (3) step(1'b1, 1'b1);
    chk("zl_done_count", 64'(n_done), 64'd1);
    chk("zl_busy", 64'(n_busy), 64'd0);
    chk("zl_qvalid", 64'(n_qv), 64'd0);
`ifdef SNAX_STREAM_PERF_CNT_EN
    chk("zl_perf", 64'(perf_cycles), 64'd0);
`endif

    run_xfer(48'hFFFF_FFFF_FFF8, 48'h8, 2, 0, 0, 0);
    chk("wrap_addr1", 64'(exp_addr(1)), 64'd0);

    r1 = {$urandom(), $urandom()};
    run_xfer(r1[AW-1:0], 48'h10, 4, 0, 3, 0);

    // Reset while issuing element 3 of 10, with a response still in flight
    clear_model(48'h2000, 48'h18, 10);
    cfg_base = 48'h2000; cfg_stride = 48'h18; cfg_len = 16'd10; start = 1'b1;
    step(1'b1, 1'b1);
    start = 1'b0;
    for (int i = 0; i < 100 && n_iss < 3; i++) step(1'b1, 1'b1);
    chk("pre_rst_issued", 64'(n_iss), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_dvalid", 64'(data_valid), 64'd0);
    chk("mid_rst_qvalid", 64'(tcdm_req.q_valid), 64'd0);
    chk("mid_rst_data", data, 64'd0);
    chk("mid_rst_addr", 64'(tcdm_req.q.addr), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model(48'h2000, 48'h18, 0);
    repeat (3) step(1'b1, 1'b1);
    chk("late_rsp_dropped", 64'(n_pop), 64'd0);
    chk("post_rst_idle_qv", 64'(n_qv), 64'd0);
    run_xfer(48'h3000, 48'h8, 2, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      run_xfer(r1[AW-1:0], r2[AW-1:0], int'($urandom_range(1, 12)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snax_tcdm_stream_reader.md
SNAX_TCDM_STREAM_READER -- requirements
Module: snax_tcdm_stream_reader

Interface
REQ-001: The block SHALL have parameter DataWidth, default 64, TCDM data and stream width in bits.
REQ-002: The block SHALL have parameter AddrWidth, default 48, TCDM byte-address width.
REQ-003: The block SHALL have parameter FifoDepth, default 4, response buffer entries, power of two, minimum 2.
REQ-004: The block SHALL have parameters tcdm_req_t and tcdm_rsp_t, default logic, the TCDM request/response structs (q_valid, q.addr, q.write, q.data, q.strb; q_ready, p_valid, p.data).
REQ-005: Ports SHALL be: clk_i input 1 clock; rst_ni input 1 reset, asynchronous, active-low.
REQ-006: cfg_base_i  input  AddrWidth  first byte address.
REQ-007: cfg_stride_i  input  AddrWidth  byte increment between elements.
REQ-008: cfg_len_i  input  16  number of elements to read.
REQ-009: start_i  input  1  start pulse; config sampled on this cycle.
REQ-010: busy_o  output  1  high from accepted start until done.
REQ-011: done_o  output  1  one-cycle pulse when transfer completes.
REQ-012: tcdm_req_o  output  tcdm_req_t  TCDM request to the memory.
REQ-013: tcdm_rsp_i  input  tcdm_rsp_t  TCDM response from the memory.
REQ-014: data_o  output  DataWidth  stream data; data_valid_o output 1; data_ready_i input 1.

Function
REQ-015: FSM SHALL have states IDLE, ISSUE, DRAIN; reset state IDLE.
REQ-016: IDLE -> ISSUE on start_i with cfg_len_i != 0; cfg latched same edge; busy_o high next cycle.
REQ-017: start_i with cfg_len_i == 0 SHALL issue no request and pulse done_o the following cycle, remaining in IDLE.
REQ-018: start_i while busy_o is high SHALL be ignored.
REQ-019: Element k address SHALL be base + k*stride, accumulated by adding stride, truncated modulo 2^AddrWidth (wrap-around allowed).
REQ-020: Requests SHALL carry q.write=0, q.strb all ones, q.data zero.
REQ-021: q_valid SHALL assert in ISSUE only when fifo_count + outstanding < FifoDepth (credit rule; p_valid has no back-pressure).
REQ-022: Once q_valid is high it SHALL hold with stable address until q_valid & q_ready.
REQ-023: Handshake q_valid & q_ready SHALL increment outstanding and element index; p_valid SHALL decrement outstanding and push p.data into FIFO; simultaneous events net to zero change.
REQ-024: ISSUE -> DRAIN on the handshake of element cfg_len-1.
REQ-025: DRAIN -> IDLE when outstanding == 0 and FIFO empty after the last pop; done_o pulses that cycle, busy_o low next cycle.
REQ-026: FIFO SHALL be first-word-fall-through; data_valid_o = !empty; pop on data_valid_o & data_ready_i; push and pop in the same cycle SHALL both occur, including when full.
REQ-027: p_valid arriving with FIFO full SHALL be impossible by REQ-021; bench asserts it.
REQ-028: Minimum latency: q handshake at cycle N -> data_valid_o at cycle N+2 with a 1-cycle memory.
REQ-029: Sustained throughput SHALL be one element per cycle when q_ready and data_ready_i stay high.

Reset
REQ-030: On rst_ni low: state IDLE, counters, outstanding and FIFO pointers zero; busy_o, done_o, data_valid_o, q_valid 0; data_o and q.addr 0.
REQ-031: Reset mid-transfer SHALL abort immediately; late p_valid after release SHALL be dropped because outstanding is zero.

Configuration
REQ-032: Macro SNAX_STREAM_PERF_CNT_EN defined SHALL add output perf_cycles_o, 32 bits: counts cycles busy_o high, cleared on accepted start, saturating at all ones, held after done.
REQ-033: Without SNAX_STREAM_PERF_CNT_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-034: base=0x0, stride=8, len=4, memory q_ready=1, data_ready_i=1 -> addresses 0x0,0x8,0x10,0x18; four beats in order; done_o one pulse.
REQ-035: len=8, data_ready_i=0 for 20 cycles -> exactly FifoDepth(4) requests issued, no FIFO overflow; on release remaining 4 issued, all 8 delivered in order.
REQ-036: len=0 start -> no q_valid; done_o high exactly one cycle later; busy_o stays 0.
REQ-037: base=0xFFFF_FFFF_FFF8, stride=8, len=2 -> addresses 0xFFFF_FFFF_FFF8 then 0x0.
REQ-038: rst_ni low during ISSUE at element 3 of 10 -> all outputs reset values next cycle; new start len=2 completes with two correct beats.
REQ-039: Macro defined, len=4, data_ready_i toggling 1/0 -> perf_cycles_o equals measured busy_o-high cycle count.
